// File: rtl/cpu_defs.sv
// Shared definitions for the CPU fetch stage.
// - Redirect kind encodings used by the PC unit.
// - Default program-counter width.
package cpu_defs;

  localparam int unsigned PC_W_DEFAULT = 48;

  localparam logic [1:0] REDIR_JUMP = 2'd0;
  localparam logic [1:0] REDIR_CALL = 2'd1;
  localparam logic [1:0] REDIR_RET  = 2'd2;
  localparam logic [1:0] REDIR_RSVD = 2'd3;  // decoded as a jump

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack (LIFO) with sticky overflow/underflow flags.
// Ports:
//   clk       : clock, all state changes on the falling edge
//   rst       : synchronous active-high reset (count, pointer, flags)
//   push      : push push_data (overwrites the oldest entry when full)
//   pop       : pop the top entry (no-op except udf when empty)
//   push_data : value to push
//   top_data  : entry at the top pointer (valid when !empty)
//   empty     : stack holds no entries
//   full      : stack holds DEPTH entries
//   ovf       : sticky, a push happened while full
//   udf       : sticky, a pop happened while empty
module pc_ras #(
  parameter int unsigned W     = 48,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         udf
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_ras: DEPTH must be a power of two and at least 2");
  end

  // Small and read combinationally for next-PC selection, so it maps to
  // distributed storage rather than block RAM.
  logic [W-1:0]     mem_reg [DEPTH];
  logic [PTR_W-1:0] top_reg, top_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             udf_reg, udf_next;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign top_data = mem_reg[top_reg];
  assign ovf      = ovf_reg;
  assign udf      = udf_reg;

  always_comb begin
    top_next   = top_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    udf_next   = udf_reg;
    if (push) begin
      // Pointer wraps naturally (power-of-two depth). When full, the slot
      // after the top is the oldest entry, so it gets overwritten.
      top_next = top_reg + 1'b1;
      if (full) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end else if (pop) begin
      if (empty) begin
        udf_next = 1'b1;
      end else begin
        top_next   = top_reg - 1'b1;
        count_next = count_reg - 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      top_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      top_reg   <= top_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  // Entry contents are don't-care after reset, so the array has no reset.
  always_ff @(negedge clk) begin
    if (!rst && push) begin
      mem_reg[top_next] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// Priority: reset > redirect > stall > increment. Calls push the return
// address (pc_out + STEP) on a circular RAS; returns pop it, falling back
// to redir_target when the RAS is empty.
// Ports:
//   clk, rst     : clock (falling-edge state updates), synchronous reset
//   stall        : hold PC when no redirect is requested
//   redir_valid  : redirect request; redir_kind selects jump/call/return
//   redir_target : jump/call target, fallback target for empty return
//   pc_out       : registered PC
//   pc_next      : combinational next PC (prefetch)
//   ras_empty/ras_full/ras_ovf/ras_udf : RAS status
module pc_unit
  import cpu_defs::*;
#(
  parameter int unsigned      PC_W      = PC_W_DEFAULT,
  parameter int unsigned      STEP      = 1,
  parameter int unsigned      RAS_DEPTH = 4,
  parameter logic [PC_W-1:0]  RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [1:0]      redir_kind,
  input  logic [PC_W-1:0] redir_target,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_ovf,
  output logic            ras_udf
);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            is_call;
  logic            is_ret;

  // Truncating add: wrap past the top of the address space is silent.
  assign pc_inc  = pc_reg + PC_W'(STEP);
  assign is_call = redir_valid && (redir_kind == REDIR_CALL);
  assign is_ret  = redir_valid && (redir_kind == REDIR_RET);

  // Redirect wins over stall: flushes originate in later stages.
  always_comb begin
    pc_next = pc_inc;
    if (redir_valid) begin
      if (is_ret && !ras_empty) begin
        pc_next = ras_top;
      end else begin
        pc_next = redir_target;
      end
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (is_call),
    .pop       (is_ret),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .udf       (ras_udf)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc_out = pc_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: two instances (48-bit default, and 8-bit with a
// 2-deep RAS and non-zero reset PC) driven by shared stimulus and compared
// each cycle against a queue-based reference model, plus directed checks.
module tb_pc_unit;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  redir_kind = 2'd0;
  logic [47:0] redir_target = '0;

  logic [47:0] pc_out_a, pc_next_a;
  logic        ras_empty_a, ras_full_a, ras_ovf_a, ras_udf_a;
  logic [7:0]  pc_out_b, pc_next_b;
  logic        ras_empty_b, ras_full_b, ras_ovf_b, ras_udf_b;

  always #5 clk = ~clk;

  pc_unit dut_a (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_kind(redir_kind), .redir_target(redir_target),
    .pc_out(pc_out_a), .pc_next(pc_next_a),
    .ras_empty(ras_empty_a), .ras_full(ras_full_a),
    .ras_ovf(ras_ovf_a), .ras_udf(ras_udf_a)
  );

  pc_unit #(.PC_W(8), .STEP(1), .RAS_DEPTH(2), .RESET_PC(8'hF0)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_kind(redir_kind), .redir_target(redir_target[7:0]),
    .pc_out(pc_out_b), .pc_next(pc_next_b),
    .ras_empty(ras_empty_b), .ras_full(ras_full_b),
    .ras_ovf(ras_ovf_b), .ras_udf(ras_udf_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  logic [63:0] m_pc   [2];
  logic [63:0] m_next [2];
  logic [63:0] m_q    [2][$];
  bit          m_ovf  [2];
  bit          m_udf  [2];
  logic [63:0] last_next_a;

  function automatic logic [63:0] msk(int i);
    return (i == 0) ? 64'h0000_FFFF_FFFF_FFFF : 64'h0000_0000_0000_00FF;
  endfunction

  function automatic int dep(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [63:0] rpc(int i);
    return (i == 0) ? 64'h0 : 64'hF0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int i, bit r, bit s, bit v, logic [1:0] k, logic [47:0] t);
    logic [63:0] tm;
    logic [63:0] inc;
    logic [63:0] nxt;
    tm  = 64'(t) & msk(i);
    inc = (m_pc[i] + 64'd1) & msk(i);
    if (r) begin
      m_pc[i] = rpc(i);
      m_q[i].delete();
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
      return;
    end
    if (v && k == 2'd1) begin
      nxt = tm;
      m_q[i].push_back(inc);
      if (m_q[i].size() > dep(i)) begin
        void'(m_q[i].pop_front());
        m_ovf[i] = 1'b1;
      end
    end else if (v && k == 2'd2) begin
      if (m_q[i].size() > 0) begin
        nxt = m_q[i].pop_back();
      end else begin
        nxt = tm;
        m_udf[i] = 1'b1;
      end
    end else if (v) begin
      nxt = tm;
    end else if (s) begin
      nxt = m_pc[i];
    end else begin
      nxt = inc;
    end
    m_next[i] = nxt;
    m_pc[i]   = nxt;
  endtask

  task automatic check_state();
    chk("pc_out_a", 64'(pc_out_a), m_pc[0]);
    chk("empty_a", 64'(ras_empty_a), 64'(m_q[0].size() == 0));
    chk("full_a", 64'(ras_full_a), 64'(m_q[0].size() == dep(0)));
    chk("ovf_a", 64'(ras_ovf_a), 64'(m_ovf[0]));
    chk("udf_a", 64'(ras_udf_a), 64'(m_udf[0]));
    chk("pc_out_b", 64'(pc_out_b), m_pc[1]);
    chk("empty_b", 64'(ras_empty_b), 64'(m_q[1].size() == 0));
    chk("full_b", 64'(ras_full_b), 64'(m_q[1].size() == dep(1)));
    chk("ovf_b", 64'(ras_ovf_b), 64'(m_ovf[1]));
    chk("udf_b", 64'(ras_udf_b), 64'(m_udf[1]));
  endtask

  // One transaction: drive after the rising edge, check pc_next, let the
  // falling edge commit, then check registered state.
  task automatic cyc(bit r, bit s, bit v, logic [1:0] k, logic [47:0] t);
    @(posedge clk);
    rst = r; stall = s; redir_valid = v; redir_kind = k; redir_target = t;
    #1;
    last_next_a = 64'(pc_next_a);
    model_step(0, r, s, v, k, t);
    model_step(1, r, s, v, k, t);
    if (!r) begin
      chk("pc_next_a", 64'(pc_next_a), m_next[0]);
      chk("pc_next_b", 64'(pc_next_b), m_next[1]);
    end
    @(negedge clk);
    #1;
    check_state();
    $display("[TB] rst=%0b stall=%0b rv=%0b kind=%0d tgt=%h pc_a=%h pc_b=%h",
             r, s, v, k, t, pc_out_a, pc_out_b);
  endtask

  task automatic idle(int n);
    for (int j = 0; j < n; j++) cyc(0, 0, 0, 2'd0, 48'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset dominates a pending call, then increment
    cyc(1, 0, 1, REDIR_CALL, 48'h55);
    cyc(1, 0, 1, REDIR_CALL, 48'h55);
    chk("t1_reset_pc", 64'(pc_out_a), 64'h0);
    chk("t1_reset_pc_b", 64'(pc_out_b), 64'hF0);
    chk("t1_reset_empty", 64'(ras_empty_a), 64'h1);
    idle(3);
    chk("t1_pc3", 64'(pc_out_a), 64'h3);
    idle(1);
    chk("t1_next4", last_next_a, 64'h4);
    idle(1);
    // 2. stall vs redirect
    cyc(0, 1, 0, REDIR_JUMP, 48'h0);
    cyc(0, 1, 0, REDIR_JUMP, 48'h0);
    chk("t2_stall", 64'(pc_out_a), 64'h5);
    cyc(0, 1, 1, REDIR_JUMP, 48'h100);
    chk("t2_jump_stall", 64'(pc_out_a), 64'h100);
    idle(1);
    chk("t2_after", 64'(pc_out_a), 64'h101);
    // 3. call / return
    cyc(0, 0, 1, REDIR_JUMP, 48'h10);
    cyc(0, 0, 1, REDIR_CALL, 48'h200);
    chk("t3_call_pc", 64'(pc_out_a), 64'h200);
    chk("t3_nonempty", 64'(ras_empty_a), 64'h0);
    idle(2);
    chk("t3_idle", 64'(pc_out_a), 64'h202);
    cyc(0, 0, 1, REDIR_RET, 48'h0);
    chk("t3_ret_pc", 64'(pc_out_a), 64'h11);
    chk("t3_ret_empty", 64'(ras_empty_a), 64'h1);
    // 4. overflow then underflow
    cyc(0, 0, 1, REDIR_JUMP, 48'h1);
    for (int j = 2; j <= 6; j++) cyc(0, 0, 1, REDIR_CALL, 48'(j));
    chk("t4_full", 64'(ras_full_a), 64'h1);
    chk("t4_ovf", 64'(ras_ovf_a), 64'h1);
    for (int j = 6; j >= 3; j--) begin
      cyc(0, 0, 1, REDIR_RET, 48'h777);
      chk("t4_ret", 64'(pc_out_a), 64'(j));
    end
    cyc(0, 0, 1, REDIR_RET, 48'h777);
    chk("t4_fallback", 64'(pc_out_a), 64'h777);
    chk("t4_udf", 64'(ras_udf_a), 64'h1);
    // 5. wrap on the 8-bit instance
    cyc(1, 0, 0, REDIR_JUMP, 48'h0);
    cyc(0, 0, 1, REDIR_JUMP, 48'hFF);
    idle(1);
    chk("t5_wrap", 64'(pc_out_b), 64'h0);
    chk("t5_ovf", 64'(ras_ovf_b), 64'h0);
    chk("t5_udf", 64'(ras_udf_b), 64'h0);
    // 6. reset in the middle of a call sequence
    cyc(0, 0, 1, REDIR_CALL, 48'h40);
    cyc(0, 0, 1, REDIR_CALL, 48'h50);
    cyc(1, 0, 1, REDIR_CALL, 48'h60);
    chk("t6_pc", 64'(pc_out_a), 64'h0);
    chk("t6_empty", 64'(ras_empty_a), 64'h1);
    chk("t6_ovf", 64'(ras_ovf_a), 64'h0);
    chk("t6_udf", 64'(ras_udf_a), 64'h0);
    cyc(0, 0, 1, REDIR_RET, 48'h333);
    chk("t6_fallback", 64'(pc_out_a), 64'h333);
    chk("t6_udf_set", 64'(ras_udf_a), 64'h1);
    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit          r, s, v;
      logic [1:0]  k;
      logic [47:0] t;
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 2) == 0);
      k = 2'($urandom_range(0, 3));
      if (!v && $urandom_range(0, 3) == 0) k = 2'bxx;
      t = {16'($urandom), $urandom};
      if ($urandom_range(0, 3) == 0) t = 48'hFFFF_FFFF_FFF0 | 48'($urandom_range(0, 15));
      cyc(r, s, v, k, t);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
